frequency_generator: RTL and testbench
======================================

FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter FREQ_W, default 26, meaning the width of frequency and count words.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port freq_in  input  FREQ_W  requested tone frequency in Hz, unsigned.
REQ-006 The block SHALL have port load  input  1  request to adopt freq_in, valid only when sampled with ready=1.
REQ-007 The block SHALL have port ready  output  1  high when a load is accepted this cycle.
REQ-008 The block SHALL have port wave_out  output  1  generated square wave, registered.
REQ-009 The block SHALL have port rise  output  1  one-cycle pulse on the cycle wave_out goes 0->1.
REQ-010 The block SHALL have port active  output  1  high while in RUN.
REQ-011 The block SHALL have port range_err  output  1  requested frequency exceeded CLK_HZ/2 and was clamped.

Function
REQ-012 The block SHALL implement states IDLE, DIVIDE and RUN; ready = (state != DIVIDE).
REQ-013 A load sampled with ready=1 and freq_in=0 SHALL go to IDLE, hold wave_out=0 and clear range_err.
REQ-014 A load sampled with ready=1 and freq_in!=0 SHALL capture freq_in, enter DIVIDE and force wave_out=0.
REQ-015 DIVIDE SHALL compute half = floor(CLK_HZ / (2*freq)) with a (FREQ_W+1)-bit divisor and FREQ_W-bit quotient.
REQ-016 DIVIDE SHALL last exactly FREQ_W cycles (ready low for FREQ_W cycles) and then enter RUN.
REQ-017 If half computes to 0 (freq > CLK_HZ/2), half SHALL be clamped to 1 and range_err set.
REQ-018 range_err SHALL stay set until the next accepted load.
REQ-019 On entry to RUN, count SHALL be 0 and wave_out 0.
REQ-020 In RUN, each cycle the block SHALL increment count; when count == half-1, it SHALL toggle wave_out and clear count (period = 2*half cycles).
REQ-021 A load in RUN with ready=1 SHALL restart from REQ-013/REQ-014, abandoning the current period immediately.
REQ-022 load asserted during DIVIDE SHALL be ignored with no side effects.
REQ-023 rise SHALL be registered and coincide with the first cycle that wave_out=1.
REQ-024 The count SHALL never wrap: half <= 2^(FREQ_W-1), so count fits in FREQ_W bits.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, wave_out=0, rise=0, active=0, range_err=0, count=0, half=0 and clear the divider state.
REQ-026 In reset, ready SHALL be 1 after release (IDLE); reset mid-DIVIDE or mid-RUN SHALL discard the pending or active frequency.
REQ-027 The first load SHALL be accepted on the first clk edge after reset deasserts.

Structure
REQ-028 Package freq_gen_pkg SHALL hold the CLK_HZ and FREQ_W defaults and the state enum {IDLE, DIVIDE, RUN}.
REQ-029 The iterative restoring divider SHALL be sub-module serial_divider (start/done, one quotient bit per cycle, async reset).
REQ-030 The top SHALL hold the FSM, half register, period counter and output registers.

Verification (bench CLK_HZ=1000, FREQ_W=26)
REQ-031 The bench SHALL cover: load freq_in=100 -> ready low 26 cycles, then active=1 and wave_out period 10 cycles (5 high/5 low), rise every 10 cycles.
REQ-032 The bench SHALL cover: load freq_in=3 -> half=166, period 332 cycles, range_err=0.
REQ-033 The bench SHALL cover: load freq_in=600 -> range_err=1, half=1, wave_out toggles every cycle; a later load 100 clears range_err.
REQ-034 The bench SHALL cover: load 100, then pulse load with freq_in=50 at DIVIDE cycle 10 -> ignored, RUN at period 10.
REQ-035 The bench SHALL cover: running at 100, load freq_in=0 -> next cycle IDLE, wave_out=0, active=0, rise never asserts.
REQ-036 The bench SHALL cover: assert reset asynchronously mid-RUN (between edges) -> outputs 0 immediately; after release load 250 -> period 4 cycles.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// Shared defaults and FSM state type for the square-wave frequency generator.
package freq_gen_pkg;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int FREQ_W_DEF = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per clock. done_o flags the final iteration
// cycle and quotient_o already carries the completed result during that cycle.
module serial_divider #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W:0]   divisor_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int SW = $clog2(W) + 1;
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    logic          busy_q, busy_d;
    logic [SW-1:0] step_q, step_d;
    logic [W:0]    rem_q, rem_d;
    logic [W:0]    dsr_q, dsr_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  quo_q, quo_d;

    logic [W+1:0]  trial;
    logic [W+1:0]  diff;
    logic          q_bit;
    logic [W:0]    rem_next;
    logic [W-1:0]  quo_next;

    // Remainder stays below the divisor, so one extra bit holds the shifted trial value.
    assign trial    = {rem_q, dvd_q[W-1]};
    assign diff     = trial - {1'b0, dsr_q};
    assign q_bit    = ~diff[W+1];
    assign rem_next = q_bit ? diff[W:0] : trial[W:0];
    assign quo_next = (quo_q << 1) | W'(q_bit);

    assign done_o     = busy_q && (step_q == LAST);
    assign quotient_o = quo_next;

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        if (start_i) begin
            busy_d = 1'b1;
            step_d = '0;
            rem_d  = '0;
            dsr_d  = divisor_i;
            dvd_d  = dividend_i;
            quo_d  = '0;
        end else if (busy_q) begin
            rem_d  = rem_next;
            dvd_d  = dvd_q << 1;
            quo_d  = quo_next;
            step_d = step_q + SW'(1);
            if (step_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
        end
    end

endmodule

// File: rtl/frequency_generator.sv
// Square-wave generator: a load latches a tone frequency, a serial divide finds the
// half period in clocks, then a counter toggles wave_out every half period.
module frequency_generator
    import freq_gen_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              load,
    output logic              ready,
    output logic              wave_out,
    output logic              rise,
    output logic              active,
    output logic              range_err
);

    localparam logic [FREQ_W-1:0] DIVIDEND = FREQ_W'(CLK_HZ);
    localparam logic [FREQ_W-1:0] ONE      = FREQ_W'(1);

    state_t            state_q, state_d;
    logic [FREQ_W-1:0] half_q, half_d;
    logic [FREQ_W-1:0] count_q, count_d;
    logic              wave_q, wave_d;
    logic              rise_q, rise_d;
    logic              err_q, err_d;

    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [FREQ_W-1:0] div_quo;

    // Handshake: load is taken on any edge where ready is high; ready drops only
    // while the divider is working, and loads seen then are dropped silently.
    assign ready     = (state_q != DIVIDE);
    assign accept    = load && ready;
    assign div_start = accept && (freq_in != '0);

    serial_divider #(.W(FREQ_W)) u_div (
        .clk        (clk),
        .rst        (reset),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  ({freq_in, 1'b0}),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        count_d = count_q;
        wave_d  = wave_q;
        rise_d  = 1'b0;
        err_d   = err_q;
        if (accept) begin
            count_d = '0;
            wave_d  = 1'b0;
            err_d   = 1'b0;
            if (freq_in == '0) begin
                state_d = IDLE;
                half_d  = '0;
            end else begin
                state_d = DIVIDE;
            end
        end else begin
            unique case (state_q)
                DIVIDE: begin
                    if (div_done) begin
                        state_d = RUN;
                        count_d = '0;
                        wave_d  = 1'b0;
                        // A zero quotient means the tone is above Nyquist for this clock.
                        if (div_quo == '0) begin
                            half_d = ONE;
                            err_d  = 1'b1;
                        end else begin
                            half_d = div_quo;
                        end
                    end
                end
                RUN: begin
                    if (count_q == half_q - ONE) begin
                        count_d = '0;
                        wave_d  = ~wave_q;
                        rise_d  = ~wave_q;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            half_q  <= '0;
            count_q <= '0;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            count_q <= count_d;
            wave_q  <= wave_d;
            rise_q  <= rise_d;
            err_q   <= err_d;
        end
    end

    assign wave_out  = wave_q;
    assign rise      = rise_q;
    assign active    = (state_q == RUN);
    assign range_err = err_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator at CLK_HZ=1000: directed scenarios plus random loads,
// every cycle checked against a closed-form model of the tone schedule.
module tb_frequency_generator;

    localparam int CLK_HZ = 1000;
    localparam int FREQ_W = 26;

    localparam int M_IDLE = 0;
    localparam int M_DIV  = 1;
    localparam int M_RUN  = 2;

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              load    = 1'b0;
    logic [FREQ_W-1:0] freq_in = '0;
    logic              ready;
    logic              wave_out;
    logic              rise;
    logic              active;
    logic              range_err;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    frequency_generator #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .freq_in   (freq_in),
        .load      (load),
        .ready     (ready),
        .wave_out  (wave_out),
        .rise      (rise),
        .active    (active),
        .range_err (range_err)
    );

    // ---------------- reference model ----------------
    int     m_mode = M_IDLE;
    longint m_t    = 0;
    longint m_freq = 0;
    longint m_half = 0;

    function automatic longint half_of(input longint f);
        longint h;
        h = CLK_HZ / (2 * f);
        return (h == 0) ? 1 : h;
    endfunction

    // Hand-derived half periods that pin the model for the directed tones.
    function automatic longint lit_half(input longint f);
        case (f)
            100:     return 5;
            3:       return 166;
            600:     return 1;
            250:     return 2;
            50:      return 10;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= M_IDLE;
            m_t    <= 0;
            m_freq <= 0;
            m_half <= 0;
        end else if (m_mode != M_DIV && load) begin
            if (freq_in == '0) begin
                m_mode <= M_IDLE;
            end else begin
                m_mode <= M_DIV;
                m_t    <= 0;
                m_freq <= longint'(freq_in);
            end
        end else if (m_mode == M_DIV) begin
            if (m_t == FREQ_W - 1) begin
                m_mode <= M_RUN;
                m_t    <= 0;
                m_half <= half_of(m_freq);
            end else begin
                m_t <= m_t + 1;
            end
        end else if (m_mode == M_RUN) begin
            m_t <= m_t + 1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    longint cyc       = 0;
    int     low_run   = 0;
    longint last_rise = -1;
    longint lit       = -1;
    logic   e_run, e_wave, e_rise, e_err;

    always begin
        @(negedge clk or posedge reset);
        if (reset) #1;
        cyc++;
        e_run  = (m_mode == M_RUN);
        e_wave = e_run && (((m_t / m_half) % 2) == 1);
        e_rise = e_run && (m_t > 0) && ((m_t % (2 * m_half)) == m_half);
        e_err  = e_run && (2 * m_freq > CLK_HZ);
        check("ready",     ready,     m_mode != M_DIV);
        check("active",    active,    e_run);
        check("wave_out",  wave_out,  e_wave);
        check("rise",      rise,      e_rise);
        check("range_err", range_err, e_err);

        lit = lit_half(m_freq);
        if (e_run && m_t == 0 && lit >= 0)
            check("model_half", m_half, lit);

        if (!ready) begin
            low_run++;
        end else begin
            if (low_run != 0) check("divide_len", low_run, FREQ_W);
            low_run = 0;
        end

        if (!e_run) begin
            last_rise = -1;
        end else if (rise) begin
            if (last_rise >= 0 && lit >= 0) check("rise_gap", cyc - last_rise, 2 * lit);
            last_rise = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [FREQ_W-1:0] f);
        @(negedge clk);
        load    = 1'b1;
        freq_in = f;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [FREQ_W-1:0] f;
        int                sel;
        #1 reset = 1'b1;
        wait_cycles(3);
        // First load presented together with reset release.
        reset   = 1'b0;
        load    = 1'b1;
        freq_in = 26'd100;
        @(negedge clk);
        load = 1'b0;
        wait_cycles(FREQ_W + 45);

        do_load(26'd3);
        wait_cycles(FREQ_W + 700);

        do_load(26'd600);
        wait_cycles(40);
        do_load(26'd100);
        wait_cycles(60);

        do_load(26'd100);
        wait_cycles(9);
        do_load(26'd50);
        wait_cycles(60);

        do_load(26'd0);
        wait_cycles(20);

        do_load(26'd100);
        wait_cycles(40);
        @(posedge clk);
        #2 reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        do_load(26'd250);
        wait_cycles(60);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       f = '0;
                1, 2:    f = FREQ_W'($urandom_range(1, 20));
                8:       f = FREQ_W'($urandom_range(501, 5000));
                9:       f = FREQ_W'($urandom);
                default: f = FREQ_W'($urandom_range(21, 600));
            endcase
            do_load(f);
            wait_cycles($urandom_range(1, 80));
        end

        wait_cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
